ame_equation_builder: RTL and testbench
=======================================

# ame_equation_builder

Streaming accumulator that builds the affine motion-estimation normal equations (6×6 matrix A, vector B) from per-pixel gradient/error samples. It sits directly upstream of the affine equation solver. Its registered 6×7 output matrix and one-cycle done pulse drive the solver's matrix input and start input, and its mode output drives the solver's 4/6-parameter mode input. Supports both the 4-parameter model (rows/cols 2..5) and the 6-parameter model (rows/cols 0..5).

## Interface
- GRAD_BITS, 16, signed width of gradient samples grad_x_i/grad_y_i
- POS_BITS, 8, unsigned width of pixel coordinates pos_x_i/pos_y_i
- DIFF_BITS, 16, signed width of prediction error diff_i
- COMP_DATA_BITS, 64, width of every accumulator and output element

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- comp_init_i  in  1  start pulse; clears accumulators, latches mode
- affine_param6_i  in  1  1 = 6-parameter model, 0 = 4-parameter model
- sample_valid_i  in  1  sample present
- sample_ready_o  out  1  builder accepts a sample this cycle
- sample_last_i  in  1  marks final sample of the block
- grad_x_i, grad_y_i  in  GRAD_BITS each  signed horizontal/vertical gradient
- pos_x_i, pos_y_i  in  POS_BITS each  unsigned pixel position in block
- diff_i  in  DIFF_BITS  signed (original − prediction)
- busy_o  out  1  high from accepted comp_init_i until comp_done_o
- comp_done_o  out  1  one-cycle pulse: comp_data_o valid
- affine_param6_o  out  1  latched mode of the completed run
- comp_data_o  out  [5:0][6:0][COMP_DATA_BITS]  row i: A[i][0..5] in cols 0..5, B[i] in col 6

## Operation
- States: IDLE, ACCUM, DRAIN, OUTPUT.
- IDLE: comp_init_i=1 -> clear all accumulators, latch affine_param6_i, go ACCUM. comp_init_i in any other state is ignored.
- ACCUM: sample_ready_o=1. A handshake is sample_valid_i & sample_ready_o. A handshake with sample_last_i=1 -> DRAIN, and sample_ready_o drops the next cycle.
- Stage 1 (registered per handshake): coefficient vector c, with all values sign-extended.
  - 6-param: c0=gx, c1=x·gx, c2=gy, c3=x·gy, c4=y·gx, c5=y·gy.
  - 4-param: c0=c1=0, c2=gx, c3=x·gx+y·gy, c4=gy, c5=y·gx−x·gy.
- Stage 2: for i≤j, A[i][j] += ci·cj (21 accumulators). B[i] += ci·diff (6 accumulators).
- Arithmetic is two's complement modulo 2^COMP_DATA_BITS; overflow wraps silently.
- DRAIN: wait until stage 1 and stage 2 are empty (2 cycles), then go OUTPUT.
- OUTPUT (1 cycle): load comp_data_o.
  - Upper triangle and B come from the accumulators; A[j][i]=A[i][j] for i<j (mirror).
  - 4-param: rows 0,1 and cols 0,1 are forced to 0.
  - Assert comp_done_o, update affine_param6_o, return to IDLE.
- comp_data_o and affine_param6_o hold until the next OUTPUT.
- Reset: state IDLE; all accumulators, comp_data_o, comp_done_o, sample_ready_o, busy_o and affine_param6_o are 0. Reset mid-run discards the run; no done pulse.
- sample_valid_i outside ACCUM: ignored, no accumulation.
- Zero-sample run is impossible: a run ends only on a sample_last_i handshake.

## Timing
- comp_init_i sampled at edge E -> sample_ready_o=1 from E+1.
- Throughput: 1 sample/cycle. sample_valid_i may drop at any cycle without loss.
- Last handshake at edge L: c registered at L+1, accumulated at L+2, comp_data_o and comp_done_o=1 after L+3.
- comp_done_o is high exactly one cycle.
- Next comp_init_i is accepted in the cycle after comp_done_o (IDLE), i.e. earliest from L+4.
- busy_o falls together with comp_done_o.

## Test plan
- Reset then idle: all outputs 0; sample_valid_i=1 without comp_init_i -> sample_ready_o stays 0, comp_data_o stays 0.
- 6-param single sample gx=1, gy=0, x=2, y=3, diff=5 with last -> c=[1,2,0,0,3,0].
  - A[0][0]=1, A[0][1]=A[1][0]=2, A[1][1]=4, A[0][4]=A[4][0]=3, A[1][4]=A[4][1]=6, A[4][4]=9.
  - B[0]=5, B[1]=10, B[4]=15; all other elements 0.
  - comp_done_o pulses 3 cycles after the handshake.
- 4-param single sample gx=1, gy=2, x=3, y=4, diff=−1 -> c=[0,0,1,11,2,−2].
  - A[3][3]=121, A[2][5]=A[5][2]=−2, A[5][5]=4, A[3][4]=22.
  - B[3]=−11, B[5]=2; rows/cols 0,1 all 0; affine_param6_o=0.
- Streaming with gaps: 64 samples of the previous 6-param sample, sample_valid_i toggled pseudo-randomly -> every element equals 64× the single-sample value; back-to-back run restarts from 0.
- comp_init_i during ACCUM/DRAIN ignored -> result unchanged. rst_n_i asserted mid-ACCUM -> no done pulse, all outputs 0, next run correct.
- Wrap check: accumulate ≥2^15 samples with gx=gy=−32768, x=y=255 in 6-param -> A[5][5] equals the exact sum modulo 2^64, and symmetry holds for every element.

Source files
------------

// File: rtl/ame_equation_builder.sv
// ame_equation_builder
//
// Streaming accumulator that builds the affine motion-estimation normal
// equations A (6x6, symmetric) and B (6) from per-pixel gradient/error
// samples. It feeds the affine equation solver directly: comp_data_o is the
// solver's matrix input, comp_done_o its start pulse, affine_param6_o its
// 4/6-parameter mode select.
//
// Ports
//   clk_i            clock
//   rst_n_i          asynchronous active-low reset
//   comp_init_i      start pulse (honoured only when idle): clears the
//                    accumulators and latches affine_param6_i
//   affine_param6_i  1 = 6-parameter model, 0 = 4-parameter model
//   sample_valid_i   sample present
//   sample_ready_o   builder accepts a sample this cycle (high only in ACCUM)
//   sample_last_i    final sample of the block
//   grad_x_i/_y_i    signed gradients
//   pos_x_i/_y_i     unsigned pixel position inside the block
//   diff_i           signed prediction error (original - prediction)
//   busy_o           high from an accepted comp_init_i until the done pulse ends
//   comp_done_o      one-cycle pulse, comp_data_o valid
//   affine_param6_o  mode of the completed run
//   comp_data_o      row i: A[i][0..5] in cols 0..5, B[i] in col 6
//
// Pipeline for a handshake at edge L:
//   L   : sample captured into the input register
//   L+1 : coefficient vector c registered
//   L+2 : products added into the accumulators
//   L+3 : comp_data_o loaded, comp_done_o high for one cycle
module ame_equation_builder #(
    parameter int GRAD_BITS      = 16,
    parameter int POS_BITS       = 8,
    parameter int DIFF_BITS      = 16,
    parameter int COMP_DATA_BITS = 64
) (
    input  logic                                   clk_i,
    input  logic                                   rst_n_i,
    input  logic                                   comp_init_i,
    input  logic                                   affine_param6_i,
    input  logic                                   sample_valid_i,
    output logic                                   sample_ready_o,
    input  logic                                   sample_last_i,
    input  logic signed [GRAD_BITS-1:0]            grad_x_i,
    input  logic signed [GRAD_BITS-1:0]            grad_y_i,
    input  logic        [POS_BITS-1:0]             pos_x_i,
    input  logic        [POS_BITS-1:0]             pos_y_i,
    input  logic signed [DIFF_BITS-1:0]            diff_i,
    output logic                                   busy_o,
    output logic                                   comp_done_o,
    output logic                                   affine_param6_o,
    output logic [5:0][6:0][COMP_DATA_BITS-1:0]    comp_data_o
);

    // Coefficient width: position*gradient is (POS_BITS+1)+GRAD_BITS signed,
    // and the 4-parameter sums of two such products need one more bit.
    localparam int C_BITS  = GRAD_BITS + POS_BITS + 2;
    localparam int PA_BITS = 2 * C_BITS;          // ci*cj
    localparam int PB_BITS = C_BITS + DIFF_BITS;  // ci*diff
    localparam int N_A     = 21;                  // upper triangle incl. diagonal

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_OUTPUT
    } state_t;

    state_t state_reg;
    logic   ready_reg;
    logic   busy_reg;
    logic   done_reg;
    logic   mode_reg;       // mode of the run in progress
    logic   mode_out_reg;   // mode of the last completed run
    logic   drain_cnt_reg;

    logic   sample_hs;
    logic   init_accept;

    // ready_reg is only ever high in ACCUM, so it doubles as the state gate.
    assign sample_hs   = sample_valid_i & ready_reg;
    assign init_accept = (state_reg == ST_IDLE) & comp_init_i;

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg     <= ST_IDLE;
            ready_reg     <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            mode_reg      <= 1'b0;
            mode_out_reg  <= 1'b0;
            drain_cnt_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    // busy drops here, on the edge that also ends the done pulse
                    busy_reg <= comp_init_i;
                    if (comp_init_i) begin
                        state_reg <= ST_ACCUM;
                        mode_reg  <= affine_param6_i;
                        ready_reg <= 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (sample_hs && sample_last_i) begin
                        state_reg     <= ST_DRAIN;
                        ready_reg     <= 1'b0;
                        drain_cnt_reg <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // two cycles: coefficient stage, then accumulate stage
                    if (drain_cnt_reg) begin
                        state_reg <= ST_OUTPUT;
                    end else begin
                        drain_cnt_reg <= 1'b1;
                    end
                end
                ST_OUTPUT: begin
                    done_reg     <= 1'b1;
                    mode_out_reg <= mode_reg;
                    state_reg    <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    ready_reg <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Input register (stage 0)
    // ------------------------------------------------------------------
    logic                        s0_valid_reg;
    logic signed [GRAD_BITS-1:0] gx_reg;
    logic signed [GRAD_BITS-1:0] gy_reg;
    logic        [POS_BITS-1:0]  x_reg;
    logic        [POS_BITS-1:0]  y_reg;
    logic signed [DIFF_BITS-1:0] diff0_reg;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s0_valid_reg <= 1'b0;
            gx_reg       <= '0;
            gy_reg       <= '0;
            x_reg        <= '0;
            y_reg        <= '0;
            diff0_reg    <= '0;
        end else begin
            s0_valid_reg <= sample_hs & ~init_accept;
            if (sample_hs) begin
                gx_reg    <= grad_x_i;
                gy_reg    <= grad_y_i;
                x_reg     <= pos_x_i;
                y_reg     <= pos_y_i;
                diff0_reg <= diff_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Coefficient vector (stage 1)
    // ------------------------------------------------------------------
    logic signed [POS_BITS:0]  xs;
    logic signed [POS_BITS:0]  ys;
    logic signed [C_BITS-1:0]  gx_ext;
    logic signed [C_BITS-1:0]  gy_ext;
    logic signed [C_BITS-1:0]  x_gx;
    logic signed [C_BITS-1:0]  x_gy;
    logic signed [C_BITS-1:0]  y_gx;
    logic signed [C_BITS-1:0]  y_gy;
    logic signed [C_BITS-1:0]  c_next [6];

    // positions are unsigned; a zero MSB keeps them positive in signed math
    assign xs     = {1'b0, x_reg};
    assign ys     = {1'b0, y_reg};
    assign gx_ext = C_BITS'(gx_reg);
    assign gy_ext = C_BITS'(gy_reg);
    assign x_gx   = C_BITS'(xs) * gx_ext;
    assign x_gy   = C_BITS'(xs) * gy_ext;
    assign y_gx   = C_BITS'(ys) * gx_ext;
    assign y_gy   = C_BITS'(ys) * gy_ext;

    always_comb begin
        for (int k = 0; k < 6; k++) begin
            c_next[k] = '0;
        end
        if (mode_reg) begin
            c_next[0] = gx_ext;
            c_next[1] = x_gx;
            c_next[2] = gy_ext;
            c_next[3] = x_gy;
            c_next[4] = y_gx;
            c_next[5] = y_gy;
        end else begin
            // 4-parameter model lives in rows/cols 2..5; c0/c1 stay 0
            c_next[2] = gx_ext;
            c_next[3] = x_gx + y_gy;
            c_next[4] = gy_ext;
            c_next[5] = y_gx - x_gy;
        end
    end

    logic                        s1_valid_reg;
    logic signed [C_BITS-1:0]    c_reg [6];
    logic signed [DIFF_BITS-1:0] diff1_reg;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_valid_reg <= 1'b0;
            diff1_reg    <= '0;
            for (int k = 0; k < 6; k++) begin
                c_reg[k] <= '0;
            end
        end else begin
            s1_valid_reg <= s0_valid_reg & ~init_accept;
            if (s0_valid_reg) begin
                diff1_reg <= diff0_reg;
                for (int k = 0; k < 6; k++) begin
                    c_reg[k] <= c_next[k];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Accumulators (stage 2). A is kept as its upper triangle only, packed
    // row by row: index(i,j) = 6i - i(i-1)/2 + (j-i) for i <= j.
    // ------------------------------------------------------------------
    logic [COMP_DATA_BITS-1:0] acc_a_q [N_A];
    logic [COMP_DATA_BITS-1:0] acc_b_q [6];

    genvar gi, gj;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_row
            for (gj = gi; gj < 6; gj++) begin : g_a
                localparam int K = gi * 6 - (gi * (gi - 1)) / 2 + (gj - gi);
                logic signed [PA_BITS-1:0]  prod_a;
                logic [COMP_DATA_BITS-1:0]  acc_reg;

                assign prod_a = PA_BITS'(c_reg[gi]) * PA_BITS'(c_reg[gj]);

                always_ff @(posedge clk_i or negedge rst_n_i) begin
                    if (!rst_n_i) begin
                        acc_reg <= '0;
                    end else if (init_accept) begin
                        acc_reg <= '0;
                    end else if (s1_valid_reg) begin
                        acc_reg <= acc_reg + COMP_DATA_BITS'(prod_a);
                    end
                end

                assign acc_a_q[K] = acc_reg;
            end

            logic signed [PB_BITS-1:0]  prod_b;
            logic [COMP_DATA_BITS-1:0]  acc_b_reg;

            assign prod_b = PB_BITS'(c_reg[gi]) * PB_BITS'(diff1_reg);

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    acc_b_reg <= '0;
                end else if (init_accept) begin
                    acc_b_reg <= '0;
                end else if (s1_valid_reg) begin
                    acc_b_reg <= acc_b_reg + COMP_DATA_BITS'(prod_b);
                end
            end

            assign acc_b_q[gi] = acc_b_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output matrix: mirror the upper triangle, append B as column 6, and
    // zero rows/cols 0,1 for the 4-parameter model.
    // ------------------------------------------------------------------
    logic [COMP_DATA_BITS-1:0] comp_next [6][7];

    generate
        for (gi = 0; gi < 6; gi++) begin : g_out_row
            for (gj = 0; gj < 7; gj++) begin : g_out_col
                localparam bit IN_4P = (gi >= 2) && (gj >= 2);
                if (gj == 6) begin : g_b
                    assign comp_next[gi][gj] = (mode_reg || IN_4P) ? acc_b_q[gi] : '0;
                end else begin : g_a
                    localparam int LO = (gi < gj) ? gi : gj;
                    localparam int HI = (gi < gj) ? gj : gi;
                    localparam int K  = LO * 6 - (LO * (LO - 1)) / 2 + (HI - LO);
                    assign comp_next[gi][gj] = (mode_reg || IN_4P) ? acc_a_q[K] : '0;
                end
            end
        end
    endgenerate

    logic [5:0][6:0][COMP_DATA_BITS-1:0] comp_data_reg;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            comp_data_reg <= '0;
        end else if (state_reg == ST_OUTPUT) begin
            for (int r = 0; r < 6; r++) begin
                for (int k = 0; k < 7; k++) begin
                    comp_data_reg[r][k] <= comp_next[r][k];
                end
            end
        end
    end

    assign sample_ready_o  = ready_reg;
    assign busy_o          = busy_reg;
    assign comp_done_o     = done_reg;
    assign affine_param6_o = mode_out_reg;
    assign comp_data_o     = comp_data_reg;

endmodule

// File: tb/tb_ame_equation_builder.sv
module tb_ame_equation_builder;

    localparam int GB = 16;
    localparam int PB = 8;
    localparam int DB = 16;
    localparam int CB = 64;

    logic                           clk_i = 1'b0;
    logic                           rst_n_i;
    logic                           comp_init_i;
    logic                           affine_param6_i;
    logic                           sample_valid_i;
    logic                           sample_ready_o;
    logic                           sample_last_i;
    logic signed [GB-1:0]           grad_x_i;
    logic signed [GB-1:0]           grad_y_i;
    logic        [PB-1:0]           pos_x_i;
    logic        [PB-1:0]           pos_y_i;
    logic signed [DB-1:0]           diff_i;
    logic                           busy_o;
    logic                           comp_done_o;
    logic                           affine_param6_o;
    logic [5:0][6:0][CB-1:0]        comp_data_o;

    always #5 clk_i = ~clk_i;

    ame_equation_builder #(
        .GRAD_BITS      (GB),
        .POS_BITS       (PB),
        .DIFF_BITS      (DB),
        .COMP_DATA_BITS (CB)
    ) dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .comp_init_i     (comp_init_i),
        .affine_param6_i (affine_param6_i),
        .sample_valid_i  (sample_valid_i),
        .sample_ready_o  (sample_ready_o),
        .sample_last_i   (sample_last_i),
        .grad_x_i        (grad_x_i),
        .grad_y_i        (grad_y_i),
        .pos_x_i         (pos_x_i),
        .pos_y_i         (pos_y_i),
        .diff_i          (diff_i),
        .busy_o          (busy_o),
        .comp_done_o     (comp_done_o),
        .affine_param6_o (affine_param6_o),
        .comp_data_o     (comp_data_o)
    );

    int     errors = 0;
    int     checks = 0;
    longint exp_m [6][7];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 7; j++)
                exp_m[i][j] = 0;
    endtask

    task automatic set_a(input int i, input int j, input longint v);
        exp_m[i][j] = v;
        exp_m[j][i] = v;
    endtask

    // 6-param sample gx=1 gy=0 x=2 y=3 diff=5 -> c=[1,2,0,0,3,0], scaled
    task automatic exp_6p(input longint s);
        clear_exp();
        set_a(0, 0, 1 * s);
        set_a(0, 1, 2 * s);
        set_a(1, 1, 4 * s);
        set_a(0, 4, 3 * s);
        set_a(1, 4, 6 * s);
        set_a(4, 4, 9 * s);
        exp_m[0][6] = 5 * s;
        exp_m[1][6] = 10 * s;
        exp_m[4][6] = 15 * s;
    endtask

    // 4-param sample gx=1 gy=2 x=3 y=4 diff=-1 -> c=[0,0,1,11,2,-2]
    task automatic exp_4p();
        clear_exp();
        set_a(2, 2, 1);
        set_a(2, 3, 11);
        set_a(2, 4, 2);
        set_a(2, 5, -2);
        set_a(3, 3, 121);
        set_a(3, 4, 22);
        set_a(3, 5, -22);
        set_a(4, 4, 4);
        set_a(4, 5, -4);
        set_a(5, 5, 4);
        exp_m[2][6] = -1;
        exp_m[3][6] = -11;
        exp_m[4][6] = -2;
        exp_m[5][6] = 2;
    endtask

    task automatic check_matrix(input string tag);
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 7; j++)
                check_val($sformatf("%s_m[%0d][%0d]", tag, i, j), comp_data_o[i][j], exp_m[i][j]);
    endtask

    // called at a negedge; returns at the negedge after the init edge
    task automatic start_run(input string tag, input bit m);
        comp_init_i     = 1'b1;
        affine_param6_i = m;
        @(negedge clk_i);
        comp_init_i = 1'b0;
        check_val({tag, "_ready"}, 64'(sample_ready_o), 64'd1);
        check_val({tag, "_busy"},  64'(busy_o),         64'd1);
    endtask

    task automatic send(input int gx, input int gy, input int x, input int y, input int d, input bit last);
        grad_x_i       = gx[15:0];
        grad_y_i       = gy[15:0];
        pos_x_i        = x[7:0];
        pos_y_i        = y[7:0];
        diff_i         = d[15:0];
        sample_last_i  = last;
        sample_valid_i = 1'b1;
        @(negedge clk_i);
        sample_valid_i = 1'b0;
        sample_last_i  = 1'b0;
    endtask

    // entered at the first negedge after the last handshake (n=1);
    // done is expected at n=4, i.e. after edge L+3
    task automatic wait_done(input string tag, input bit poke_init);
        int n;
        n = 1;
        if (poke_init) begin
            comp_init_i     = 1'b1;
            affine_param6_i = 1'b0;
        end
        while (comp_done_o !== 1'b1 && n < 12) begin
            @(negedge clk_i);
            comp_init_i = 1'b0;
            n++;
        end
        comp_init_i = 1'b0;
        check_val({tag, "_done_lat"}, 64'(n), 64'd4);
    endtask

    task automatic idle_step(input string tag);
        @(negedge clk_i);
        check_val({tag, "_done_pulse"}, 64'(comp_done_o),    64'd0);
        check_val({tag, "_busy_idle"},  64'(busy_o),         64'd0);
        check_val({tag, "_ready_idle"}, 64'(sample_ready_o), 64'd0);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        longint cv [6];
        bit     seen;

        rst_n_i         = 1'b0;
        comp_init_i     = 1'b0;
        affine_param6_i = 1'b0;
        sample_valid_i  = 1'b0;
        sample_last_i   = 1'b0;
        grad_x_i        = '0;
        grad_y_i        = '0;
        pos_x_i         = '0;
        pos_y_i         = '0;
        diff_i          = '0;
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;

        // idle: valid without init is ignored
        sample_valid_i = 1'b1;
        grad_x_i = 16'sd7;
        repeat (3) @(negedge clk_i);
        check_val("idle_ready", 64'(sample_ready_o),  64'd0);
        check_val("idle_busy",  64'(busy_o),          64'd0);
        check_val("idle_done",  64'(comp_done_o),     64'd0);
        check_val("idle_mode",  64'(affine_param6_o), 64'd0);
        clear_exp();
        check_matrix("idle");
        sample_valid_i = 1'b0;
        $display("txn idle: errors so far %0d", errors);

        // 6-param single sample
        @(negedge clk_i);
        start_run("p6", 1'b1);
        send(1, 0, 2, 3, 5, 1'b1);
        wait_done("p6", 1'b0);
        exp_6p(1);
        check_matrix("p6");
        check_val("p6_mode", 64'(affine_param6_o), 64'd1);
        idle_step("p6");
        $display("txn p6 single: errors so far %0d", errors);

        // 4-param single sample
        start_run("p4", 1'b0);
        send(1, 2, 3, 4, -1, 1'b1);
        wait_done("p4", 1'b0);
        exp_4p();
        check_matrix("p4");
        check_val("p4_mode", 64'(affine_param6_o), 64'd0);
        idle_step("p4");
        $display("txn p4 single: errors so far %0d", errors);

        // streaming with gaps, then a back-to-back run
        start_run("str", 1'b1);
        for (int k = 0; k < 64; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
            send(1, 0, 2, 3, 5, k == 63);
        end
        wait_done("str", 1'b0);
        exp_6p(64);
        check_matrix("str");
        check_val("str_mode", 64'(affine_param6_o), 64'd1);
        $display("txn stream 64: errors so far %0d", errors);
        start_run("b2b", 1'b1);
        send(1, 0, 2, 3, 5, 1'b1);
        wait_done("b2b", 1'b0);
        exp_6p(1);
        check_matrix("b2b");
        idle_step("b2b");
        $display("txn back-to-back: errors so far %0d", errors);

        // comp_init during ACCUM and DRAIN is ignored
        start_run("ign", 1'b1);
        send(1, 0, 2, 3, 5, 1'b0);
        comp_init_i     = 1'b1;
        affine_param6_i = 1'b0;
        @(negedge clk_i);
        comp_init_i = 1'b0;
        send(1, 0, 2, 3, 5, 1'b1);
        wait_done("ign", 1'b1);
        exp_6p(2);
        check_matrix("ign");
        check_val("ign_mode", 64'(affine_param6_o), 64'd1);
        idle_step("ign");
        $display("txn init ignored: errors so far %0d", errors);

        // reset mid-ACCUM
        start_run("rst", 1'b0);
        send(1, 2, 3, 4, -1, 1'b0);
        send(1, 2, 3, 4, -1, 1'b0);
        send(1, 2, 3, 4, -1, 1'b0);
        rst_n_i = 1'b0;
        #1;
        check_val("rst_ready", 64'(sample_ready_o),  64'd0);
        check_val("rst_busy",  64'(busy_o),          64'd0);
        check_val("rst_done",  64'(comp_done_o),     64'd0);
        check_val("rst_mode",  64'(affine_param6_o), 64'd0);
        clear_exp();
        check_matrix("rst");
        @(negedge clk_i);
        rst_n_i = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk_i);
            if (comp_done_o) seen = 1'b1;
        end
        check_val("rst_no_done", 64'(seen), 64'd0);
        start_run("rst2", 1'b0);
        send(1, 2, 3, 4, -1, 1'b1);
        wait_done("rst2", 1'b0);
        exp_4p();
        check_matrix("rst2");
        idle_step("rst2");
        $display("txn reset mid-run: errors so far %0d", errors);

        // large-magnitude run, 2^15 samples
        start_run("big", 1'b1);
        for (int k = 0; k < 32768; k++) begin
            send(-32768, -32768, 255, 255, 7, k == 32767);
        end
        wait_done("big", 1'b0);
        cv[0] = -32768;
        cv[1] = -8355840;
        cv[2] = -32768;
        cv[3] = -8355840;
        cv[4] = -8355840;
        cv[5] = -8355840;
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 6; j++)
                exp_m[i][j] = 32768 * cv[i] * cv[j];
            exp_m[i][6] = 32768 * 7 * cv[i];
        end
        check_matrix("big");
        check_val("big_a55", comp_data_o[5][5], 64'd65025 << 45);
        $display("txn large run: errors so far %0d", errors);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
